// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream beat, downstream beat and occupancy.
// The flush signal exists only when PIPE_SKID_FLUSH_EN is defined.
interface pipe_skid_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;
`ifdef PIPE_SKID_FLUSH_EN
    logic             flush;
`endif

    // master: the surrounding logic; slave: the skid register itself
    modport master (
        output in_valid, in_data, out_ready,
`ifdef PIPE_SKID_FLUSH_EN
        output flush,
`endif
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
`ifdef PIPE_SKID_FLUSH_EN
        input  flush,
`endif
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: main register drives out_data, skid register absorbs one beat of backpressure.
// Define PIPE_SKID_FLUSH_EN to add a flush input that empties the block.
module pipe_skid_reg #(
    parameter int unsigned          WIDTH       = 32,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    pipe_skid_reg_if.slave          bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       count_q;

    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // Handshakes qualify only against registered ready/valid, so no input-to-output path exists.
    assign in_fire  = bus.in_valid  & in_ready_q;
    assign out_fire = bus.out_ready & out_valid_q;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        // Flush wins over everything: the incoming beat is dropped and no register is rewritten.
        if (bus.flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            main_q      <= RESET_VALUE;
            skid_q      <= RESET_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != FULL);
            out_valid_q <= (state_nxt != EMPTY);
            count_q     <= state_nxt;
            if (load_main_in) begin
                main_q <= bus.in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign bus.count     = count_q;

    a_count_range: assert property (@(posedge clk) disable iff (!reset) count_q != 2'd3);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: vector table for steady-state behaviour, hand sequences for
// reset, async reset mid-operation and (when PIPE_SKID_FLUSH_EN is defined) flush.
module tb_pipe_skid_reg;
    localparam int unsigned WIDTH = 32;
    localparam logic [WIDTH-1:0] RV = '0;

    logic clk;
    logic reset;

    pipe_skid_reg_if #(.WIDTH(WIDTH)) bus ();

    pipe_skid_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] din;
        logic             ordy;
        logic [1:0]       e_count;
        logic             e_ov;
        logic             e_ir;
        logic             chk_data;
        logic [WIDTH-1:0] e_data;
    } vec_t;

    localparam int unsigned NV = 18;
    vec_t vecs [NV];

    int passed;
    int total;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_state(input string name, input logic [1:0] c, input logic ov, input logic ir);
        check({name, " count"}, WIDTH'(bus.count), WIDTH'(c));
        check({name, " out_valid"}, WIDTH'(bus.out_valid), WIDTH'(ov));
        check({name, " in_ready"}, WIDTH'(bus.in_ready), WIDTH'(ir));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        passed = 0;
        total  = 0;

        // streaming 1..8, then drain
        for (int unsigned k = 0; k < 8; k++)
            vecs[k] = '{1'b1, WIDTH'(k + 1), 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, WIDTH'(k + 1)};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0};
        // backpressure: A, B, then C blocked while full
        vecs[9]  = '{1'b1, 32'hA,  1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 32'hA};
        vecs[10] = '{1'b1, 32'hB,  1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 32'hA};
        vecs[11] = '{1'b1, 32'hC,  1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 32'hA};
        vecs[12] = '{1'b1, 32'hC,  1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'hB};
        vecs[13] = '{1'b1, 32'hC,  1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 32'hC};
        vecs[14] = '{1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0};
        // stall in ONE: output must hold
        vecs[15] = '{1'b1, 32'h11, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 32'h11};
        vecs[16] = '{1'b0, 32'h99, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 32'h11};
        vecs[17] = '{1'b0, 32'h0,  1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 32'h0};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        #12;
        check_state("in_reset", 2'd0, 1'b0, 1'b1);
        check("in_reset out_data", bus.out_data, RV);
        @(negedge clk);
        reset = 1'b1;
        step();
        step();
        check_state("idle", 2'd0, 1'b0, 1'b1);
        check("idle out_data", bus.out_data, RV);

        for (int unsigned i = 0; i < NV; i++) begin
            bus.in_valid  = vecs[i].iv;
            bus.in_data   = vecs[i].din;
            bus.out_ready = vecs[i].ordy;
            step();
            check_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_ov, vecs[i].e_ir);
            if (vecs[i].chk_data)
                check($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].e_data);
        end

`ifdef PIPE_SKID_FLUSH_EN
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h5;
        step();
        bus.in_data   = 32'h6;
        step();
        check_state("flush_pre", 2'd2, 1'b1, 1'b0);
        bus.in_data   = 32'h7;
        bus.flush     = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        check_state("flush", 2'd0, 1'b0, 1'b1);
        check("flush data kept", bus.out_data, 32'h5);
        bus.out_ready = 1'b1;
        for (int unsigned j = 0; j < 3; j++) begin
            step();
            check($sformatf("flush_after%0d out_valid", j), WIDTH'(bus.out_valid), '0);
        end
`endif

        // async reset at count=2, asserted between clock edges
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h21;
        step();
        bus.in_data   = 32'h22;
        step();
        bus.in_valid  = 1'b0;
        check_state("pre_areset", 2'd2, 1'b1, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check_state("areset", 2'd0, 1'b0, 1'b1);
        check("areset out_data", bus.out_data, RV);
        #2;
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h33;
        check_state("post_areset", 2'd0, 1'b0, 1'b1);
        check("post_areset out_data", bus.out_data, RV);
        step();
        bus.in_valid  = 1'b0;
        check_state("first_edge", 2'd1, 1'b1, 1'b1);
        check("first_edge out_data", bus.out_data, 32'h33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, data payload width in bits (1..64).
REQ-002 Parameter RESET_VALUE, default 0, value loaded into both data registers on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_ready  output  1  block can accept a beat this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 out_valid  output  1  downstream beat present.
REQ-009 out_ready  input  1  downstream accepts a beat this cycle.
REQ-010 out_data  output  WIDTH  downstream payload, driven from the main register only.
REQ-011 count  output  2  occupancy: 0, 1 or 2 beats held.
REQ-012 flush  input  1  discard all held beats; present only when PIPE_SKID_FLUSH_EN is defined.

Function
REQ-013 Transfer on a port occurs when valid and ready are both high at a rising clk edge.
REQ-014 Storage: main register (feeds out_data) plus one skid register; state encoded as EMPTY (count 0), ONE (count 1), FULL (count 2).
REQ-015 in_ready SHALL equal (state != FULL), decoded from registered state only, with no combinational path from out_ready or in_valid.
REQ-016 out_valid SHALL equal (state != EMPTY).
REQ-017 EMPTY: an input transfer loads main <= in_data and moves to ONE; otherwise hold.
REQ-018 ONE: input transfer plus output transfer loads main <= in_data and stays in ONE; input transfer only loads skid <= in_data and moves to FULL; output transfer only moves to EMPTY; neither holds.
REQ-019 FULL: an output transfer loads main <= skid and moves to ONE; otherwise hold; in_valid is ignored.
REQ-020 Latency: a beat accepted in EMPTY appears on out_data/out_valid exactly 1 cycle after the accepting edge.
REQ-021 Ordering: beats leave in acceptance order; there is no loss or duplication outside flush.
REQ-022 Sustained throughput is 1 beat/cycle when out_ready is held high.
REQ-023 out_data and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 Data registers are not cleared on EMPTY transitions; out_data is don't-care while out_valid=0.
REQ-025 count SHALL never exceed 2; the encoding 3 is unreachable.

Reset
REQ-026 While reset=0: state EMPTY, count=0, out_valid=0, in_ready=1, main=skid=RESET_VALUE, out_data=RESET_VALUE.
REQ-027 Reset asserted mid-operation discards all held beats immediately and asynchronously, with no partial transfer completed.
REQ-028 The first input transfer can occur on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro PIPE_SKID_FLUSH_EN controls the flush feature.
REQ-030 With PIPE_SKID_FLUSH_EN defined: flush=1 at an edge forces state EMPTY; it dominates all other transitions; an input beat transferred that cycle is dropped; an output beat transferred that cycle counts as delivered; data registers are unchanged.
REQ-031 Without PIPE_SKID_FLUSH_EN: the flush port does not exist and state changes only per REQ-017..REQ-019.

Verification
REQ-032 Reset then idle: count=0, out_valid=0, in_ready=1, out_data=RESET_VALUE (0).
REQ-033 Streaming: in_valid=1 with data 0x1..0x8 on consecutive cycles, out_ready=1 -> out_data 0x1..0x8 each appear one cycle later, no bubbles, count=1 throughout.
REQ-034 Backpressure: push 0xA, 0xB with out_ready=0 -> count=2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB delivered, count 2->1->0.
REQ-035 Full with in_valid=1 and data 0xC -> 0xC is not accepted; it is accepted once in_ready returns to 1, and delivered after 0xB.
REQ-036 Flush (macro on): hold 0x5 and 0x6 (count=2), assert flush with in_valid=1 and data 0x7 -> next cycle count=0, out_valid=0, and 0x7 is never delivered.
REQ-037 Async reset asserted mid-cycle at count=2 -> out_valid drops before the next clk edge; after release, count=0 and out_data=RESET_VALUE.
